// File: rtl/neuron_seq_pkg.sv
// Shared types and default sizes for the Neuron MAC sequencer.
package neuron_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        BIAS  = 3'd2,
        FEED  = 3'd3,
        LAST  = 3'd4,
        CAPT  = 3'd5
    } state_e;

    localparam int unsigned W_WEIGHT     = 32;
    localparam int unsigned W_PIXEL_DATA = 8;
    localparam int unsigned W_BIAS       = 32;
    localparam int unsigned W_RESULT     = 32;

    localparam int unsigned NN_INPUTS    = 49;
    localparam int unsigned NN_NEURONS   = 10;

endpackage

// File: rtl/neuron_sequencer.sv
// Drives one Neuron evaluation per job: clear, bias, stream RAM pairs, capture sigma.
// Optional build macro NEURON_SEQ_RELU_EN clamps a negative captured sigma to zero.
module neuron_sequencer #(
    parameter int unsigned N_INPUTS     = neuron_seq_pkg::NN_INPUTS,
    parameter int unsigned N_NEURONS    = neuron_seq_pkg::NN_NEURONS,
    parameter int unsigned W_WEIGHT     = neuron_seq_pkg::W_WEIGHT,
    parameter int unsigned W_PIXEL_DATA = neuron_seq_pkg::W_PIXEL_DATA,
    parameter int unsigned W_BIAS       = neuron_seq_pkg::W_BIAS,
    parameter int unsigned W_RESULT     = neuron_seq_pkg::W_RESULT,
    parameter int unsigned W_PADDR      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    parameter int unsigned W_WADDR      = (N_INPUTS * N_NEURONS > 1) ? $clog2(N_INPUTS * N_NEURONS) : 1,
    parameter int unsigned W_NSEL       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [W_NSEL-1:0]       neuron_sel_i,
    input  logic [W_BIAS-1:0]       bias_i,
    output logic                    busy_o,
    output logic [W_PADDR-1:0]      pixel_addr_o,
    input  logic [W_PIXEL_DATA-1:0] pixel_rdata_i,
    output logic [W_WADDR-1:0]      weight_addr_o,
    input  logic [W_WEIGHT-1:0]     weight_rdata_i,
    output logic                    n_clear_o,
    output logic                    n_set_bias_o,
    output logic [W_BIAS-1:0]       n_bias_o,
    output logic                    n_active_o,
    output logic [W_PIXEL_DATA-1:0] n_pixel_o,
    output logic [W_WEIGHT-1:0]     n_weight_o,
    input  logic [W_RESULT-1:0]     n_sigma_i,
    output logic [W_RESULT-1:0]     result_o,
    output logic                    done_o
);
    import neuron_seq_pkg::*;

    localparam logic [W_PADDR-1:0] LAST_IDX = W_PADDR'(N_INPUTS - 1);
    localparam logic [W_NSEL-1:0]  MAX_NSEL = W_NSEL'(N_NEURONS - 1);

    state_e              state_q, state_d;
    logic [W_PADDR-1:0]  idx_q, idx_d;
    logic [W_WADDR-1:0]  waddr_q, waddr_d;
    logic [W_WADDR-1:0]  base_q, base_d;
    logic [W_BIAS-1:0]   bias_q, bias_d;
    logic [W_BIAS-1:0]   n_bias_q, n_bias_d;
    logic [W_RESULT-1:0] result_q, result_d;
    logic                busy_q, busy_d;
    logic                n_clear_q, n_clear_d;
    logic                n_set_bias_q, n_set_bias_d;
    logic                n_active_q, n_active_d;
    logic                done_q, done_d;

    logic [W_NSEL-1:0]   nsel_clamped_c;
    logic [W_WADDR-1:0]  base_c;
    logic [W_RESULT-1:0] capt_val_c;

    // Out-of-range neuron indices fall back to the last neuron so the weight address never wraps.
    assign nsel_clamped_c = (32'(neuron_sel_i) >= N_NEURONS) ? MAX_NSEL : neuron_sel_i;
    assign base_c         = W_WADDR'(nsel_clamped_c) * W_WADDR'(N_INPUTS);

`ifdef NEURON_SEQ_RELU_EN
    assign capt_val_c = n_sigma_i[W_RESULT-1] ? '0 : n_sigma_i;
`else
    assign capt_val_c = n_sigma_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            waddr_q      <= '0;
            base_q       <= '0;
            bias_q       <= '0;
            n_bias_q     <= '0;
            result_q     <= '0;
            busy_q       <= 1'b0;
            n_clear_q    <= 1'b0;
            n_set_bias_q <= 1'b0;
            n_active_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            waddr_q      <= waddr_d;
            base_q       <= base_d;
            bias_q       <= bias_d;
            n_bias_q     <= n_bias_d;
            result_q     <= result_d;
            busy_q       <= busy_d;
            n_clear_q    <= n_clear_d;
            n_set_bias_q <= n_set_bias_d;
            n_active_q   <= n_active_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic; strobes are registered from the upcoming state so they line up with it.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        waddr_d  = waddr_q;
        base_d   = base_q;
        bias_d   = bias_q;
        n_bias_d = n_bias_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d  = base_c;
                    bias_d  = bias_i;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                n_bias_d = bias_q;
                state_d  = BIAS;
            end
            BIAS: begin
                idx_d   = '0;
                waddr_d = base_q;
                state_d = FEED;
            end
            FEED: begin
                if (idx_q == LAST_IDX) begin
                    state_d = LAST;
                end else begin
                    idx_d   = idx_q + W_PADDR'(1);
                    waddr_d = waddr_q + W_WADDR'(1);
                end
            end
            LAST: begin
                state_d = CAPT;
            end
            CAPT: begin
                result_d = capt_val_c;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d != IDLE);
        n_clear_d    = (state_d == CLEAR);
        n_set_bias_d = (state_d == BIAS);
        // Delayed one cycle to match the synchronous RAM read latency.
        n_active_d   = (state_q == FEED);
    end

    assign busy_o        = busy_q;
    assign pixel_addr_o  = idx_q;
    assign weight_addr_o = waddr_q;
    assign n_clear_o     = n_clear_q;
    assign n_set_bias_o  = n_set_bias_q;
    assign n_bias_o      = n_bias_q;
    assign n_active_o    = n_active_q;
    assign n_pixel_o     = pixel_rdata_i;
    assign n_weight_o    = weight_rdata_i;
    assign result_o      = result_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Bench for neuron_sequencer: RAM and Neuron models plus a sum-of-products reference.
module tb_neuron_sequencer;

    localparam int N  = 49;
    localparam int NN = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, busy, n_clear, n_set_bias, n_active, done;
    logic [3:0]  nsel;
    logic [31:0] bias, n_bias, n_weight, wrdata, sigma, result;
    logic [5:0]  paddr;
    logic [8:0]  waddr;
    logic [7:0]  prdata, n_pixel;
    logic [7:0]  pmem [N];
    logic [31:0] wmem [N*NN];

    logic        s_start, s_nsel, s_busy, s_paddr, s_waddr, s_clear, s_setb, s_active, s_done;
    logic [31:0] s_bias, s_nbias, s_wrdata, s_weight, s_sigma, s_result;
    logic [7:0]  s_prdata, s_pixel;
    logic [7:0]  s_pmem [2];
    logic [31:0] s_wmem [2];

    int checks = 0;
    int errors = 0;

    neuron_sequencer #(.N_INPUTS(N), .N_NEURONS(NN)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .neuron_sel_i(nsel), .bias_i(bias),
        .busy_o(busy), .pixel_addr_o(paddr), .pixel_rdata_i(prdata),
        .weight_addr_o(waddr), .weight_rdata_i(wrdata),
        .n_clear_o(n_clear), .n_set_bias_o(n_set_bias), .n_bias_o(n_bias),
        .n_active_o(n_active), .n_pixel_o(n_pixel), .n_weight_o(n_weight),
        .n_sigma_i(sigma), .result_o(result), .done_o(done)
    );

    neuron_sequencer #(.N_INPUTS(1), .N_NEURONS(1)) dut_small (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .neuron_sel_i(s_nsel), .bias_i(s_bias),
        .busy_o(s_busy), .pixel_addr_o(s_paddr), .pixel_rdata_i(s_prdata),
        .weight_addr_o(s_waddr), .weight_rdata_i(s_wrdata),
        .n_clear_o(s_clear), .n_set_bias_o(s_setb), .n_bias_o(s_nbias),
        .n_active_o(s_active), .n_pixel_o(s_pixel), .n_weight_o(s_weight),
        .n_sigma_i(s_sigma), .result_o(s_result), .done_o(s_done)
    );

    // Synchronous RAMs and behavioural Neuron accumulators
    always @(posedge clk) begin
        prdata   <= pmem[paddr];
        wrdata   <= wmem[waddr];
        s_prdata <= s_pmem[s_paddr];
        s_wrdata <= s_wmem[s_waddr];
        if (n_clear)         sigma <= 32'd0;
        else if (n_set_bias) sigma <= n_bias;
        else if (n_active)   sigma <= sigma + 32'(n_pixel) * n_weight;
        if (s_clear)         s_sigma <= 32'd0;
        else if (s_setb)     s_sigma <= s_nbias;
        else if (s_active)   s_sigma <= s_sigma + 32'(s_pixel) * s_weight;
    end

    function automatic logic [31:0] model(input logic [3:0] ns, input logic [31:0] b);
        int sel;
        logic [31:0] acc;
        sel = (int'(ns) >= NN) ? NN - 1 : int'(ns);
        acc = b;
        for (int k = 0; k < N; k++) acc = acc + 32'(pmem[k]) * wmem[sel*N + k];
`ifdef NEURON_SEQ_RELU_EN
        if (acc[31]) acc = 32'd0;
`endif
        return acc;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < N; k++) pmem[k] = 8'($urandom);
        for (int k = 0; k < N*NN; k++) wmem[k] = $urandom;
    endtask

    // Observations of one job, cycle 0 = the cycle start is presented
    int obs_clear_cnt, obs_clear_cyc, obs_setb_cnt, obs_setb_cyc;
    int obs_act_cnt, obs_act_first, obs_act_last, obs_done_cnt, obs_done_cyc, obs_addr_err;
    logic [31:0] obs_setb_val, obs_result;
    logic obs_busy_mid, obs_busy_done, obs_post_rst_zero;

    task automatic run_job(input logic [3:0] ns, input logic [31:0] b, input int extra_start_at,
                           input int rst_at, input int max_cyc, input bit stop_on_done);
        int base;
        base = ((int'(ns) >= NN) ? NN - 1 : int'(ns)) * N;
        obs_clear_cnt = 0; obs_clear_cyc = -1; obs_setb_cnt = 0; obs_setb_cyc = -1;
        obs_act_cnt = 0; obs_act_first = -1; obs_act_last = -1;
        obs_done_cnt = 0; obs_done_cyc = -1; obs_addr_err = 0;
        obs_setb_val = 'x; obs_result = 'x; obs_busy_mid = 1'bx; obs_busy_done = 1'bx;
        obs_post_rst_zero = 1'b0;
        start = 1'b1; nsel = ns; bias = b;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (n_clear) begin obs_clear_cnt++; obs_clear_cyc = c; end
            if (n_set_bias) begin obs_setb_cnt++; obs_setb_cyc = c; obs_setb_val = n_bias; end
            if (n_active) begin
                obs_act_cnt++;
                if (obs_act_first < 0) obs_act_first = c;
                obs_act_last = c;
            end
            if (rst_at < 0 && c >= 3 && c <= N + 2)
                if (paddr !== 6'(c - 3) || waddr !== 9'(base + c - 3)) obs_addr_err++;
            if (c == 10) obs_busy_mid = busy;
            if (rst_at >= 0 && c == rst_at + 1)
                obs_post_rst_zero = ({busy, n_clear, n_set_bias, n_active, done} === 5'b0) &&
                                    (result === 32'd0) && (n_bias === 32'd0) &&
                                    (paddr === 6'd0) && (waddr === 9'd0);
            if (done) begin
                obs_done_cnt++; obs_done_cyc = c; obs_result = result; obs_busy_done = busy;
            end
            start = (c == extra_start_at);
            rst   = (c == rst_at);
            nsel  = 4'($urandom);
            bias  = $urandom;
            if (stop_on_done && done) break;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; s_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({n_clear, n_set_bias, n_active, done} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes: got %b want 0000", {n_clear, n_set_bias, n_active, done}); end
        checks++; if (result !== 32'd0 || n_bias !== 32'd0) begin
            errors++; $display("FAIL reset_data: result %h n_bias %h want 0", result, n_bias); end
        checks++; if (paddr !== 6'd0 || waddr !== 9'd0) begin
            errors++; $display("FAIL reset_addr: paddr %0d waddr %0d want 0", paddr, waddr); end
        checks++; if (s_busy !== 1'b0 || s_result !== 32'd0) begin
            errors++; $display("FAIL reset_small: busy %b result %h want 0", s_busy, s_result); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timing();
        for (int k = 0; k < N; k++) pmem[k] = 8'd1;
        for (int k = 0; k < N*NN; k++) wmem[k] = 32'd2;
        run_job(4'd0, 32'd5, -1, -1, 60, 1'b1);
        checks++; if (obs_clear_cyc !== 1 || obs_clear_cnt !== 1) begin
            errors++; $display("FAIL timing_clear: cycle %0d count %0d want 1/1", obs_clear_cyc, obs_clear_cnt); end
        checks++; if (obs_setb_cyc !== 2 || obs_setb_cnt !== 1) begin
            errors++; $display("FAIL timing_set_bias: cycle %0d count %0d want 2/1", obs_setb_cyc, obs_setb_cnt); end
        checks++; if (obs_setb_val !== 32'd5) begin
            errors++; $display("FAIL timing_n_bias: got %0d want 5", obs_setb_val); end
        checks++; if (obs_act_cnt !== N || obs_act_first !== 4 || obs_act_last !== N + 3) begin
            errors++; $display("FAIL timing_active: count %0d first %0d last %0d want %0d/4/%0d",
                               obs_act_cnt, obs_act_first, obs_act_last, N, N + 3); end
        checks++; if (obs_done_cyc !== N + 5) begin
            errors++; $display("FAIL timing_done: cycle %0d want %0d", obs_done_cyc, N + 5); end
        checks++; if (obs_result !== 32'd103) begin
            errors++; $display("FAIL timing_result: got %0d want 103", obs_result); end
        checks++; if (obs_busy_mid !== 1'b1 || obs_busy_done !== 1'b0) begin
            errors++; $display("FAIL timing_busy: mid %b at_done %b want 1/0", obs_busy_mid, obs_busy_done); end
    endtask

    task automatic test_addressing();
        logic [3:0]  ns;
        logic [31:0] b, exp;
        for (int k = 0; k < N; k++) pmem[k] = 8'($urandom);
        for (int k = 0; k < N*NN; k++) wmem[k] = 32'(k);
        b = $urandom; exp = model(4'd3, b);
        run_job(4'd3, b, -1, -1, 60, 1'b1);
        checks++; if (obs_addr_err !== 0) begin
            errors++; $display("FAIL addr_sweep_nsel3: %0d bad cycles want 0", obs_addr_err); end
        checks++; if (obs_result !== exp) begin
            errors++; $display("FAIL addr_result_nsel3: got %h want %h", obs_result, exp); end
        for (int i = 0; i < 4; i++) begin
            fill_random();
            ns = (i == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            b = $urandom; exp = model(ns, b);
            run_job(ns, b, -1, -1, 60, 1'b1);
            checks++; if (obs_addr_err !== 0 || obs_done_cyc !== N + 5) begin
                errors++; $display("FAIL rand_addr_timing[%0d] nsel %0d: bad %0d done %0d want 0/%0d",
                                   i, ns, obs_addr_err, obs_done_cyc, N + 5); end
            checks++; if (obs_result !== exp) begin
                errors++; $display("FAIL rand_result[%0d] nsel %0d: got %h want %h", i, ns, obs_result, exp); end
        end
    endtask

    task automatic test_busy();
        logic [3:0]  ns;
        logic [31:0] b, exp;
        fill_random();
        ns = 4'($urandom_range(0, 9)); b = $urandom; exp = model(ns, b);
        run_job(ns, b, 10, -1, 120, 1'b0);
        checks++; if (obs_done_cnt !== 1 || obs_done_cyc !== N + 5) begin
            errors++; $display("FAIL busy_ignore: dones %0d last %0d want 1/%0d", obs_done_cnt, obs_done_cyc, N + 5); end
        checks++; if (obs_result !== exp) begin
            errors++; $display("FAIL busy_result: got %h want %h", obs_result, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] b1, b2, e1, e2;
        fill_random();
        b1 = $urandom; b2 = $urandom; e1 = model(4'd1, b1); e2 = model(4'd7, b2);
        run_job(4'd1, b1, -1, -1, 60, 1'b1);
        checks++; if (obs_done_cyc !== N + 5 || obs_result !== e1) begin
            errors++; $display("FAIL b2b_first: done %0d result %h want %0d/%h", obs_done_cyc, obs_result, N + 5, e1); end
        run_job(4'd7, b2, -1, -1, 60, 1'b1);
        checks++; if (obs_done_cyc !== N + 5 || obs_result !== e2) begin
            errors++; $display("FAIL b2b_second: done %0d result %h want %0d/%h", obs_done_cyc, obs_result, N + 5, e2); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] b, exp;
        fill_random();
        run_job(4'd4, $urandom, -1, 20, 80, 1'b0);
        checks++; if (obs_post_rst_zero !== 1'b1) begin
            errors++; $display("FAIL midreset_outputs: zero %b want 1", obs_post_rst_zero); end
        checks++; if (obs_done_cnt !== 0) begin
            errors++; $display("FAIL midreset_no_done: dones %0d want 0", obs_done_cnt); end
        b = $urandom; exp = model(4'd5, b);
        run_job(4'd5, b, -1, -1, 60, 1'b1);
        checks++; if (obs_done_cyc !== N + 5 || obs_result !== exp) begin
            errors++; $display("FAIL midreset_recover: done %0d result %h want %0d/%h", obs_done_cyc, obs_result, N + 5, exp); end
    endtask

    task automatic test_relu();
        logic [31:0] exp;
        fill_random();
        for (int k = 0; k < N*NN; k++) wmem[k] = 32'd0;
`ifdef NEURON_SEQ_RELU_EN
        exp = 32'd0;
`else
        exp = 32'hFFFFFC18;
`endif
        run_job(4'd2, -32'sd1000, -1, -1, 60, 1'b1);
        checks++; if (obs_result !== exp || obs_done_cyc !== N + 5) begin
            errors++; $display("FAIL relu_negative: result %h done %0d want %h/%0d", obs_result, obs_done_cyc, exp, N + 5); end
    endtask

    task automatic test_small();
        logic [31:0] b, exp;
        int done_cyc, act_cnt;
        logic addr_ok, res_seen;
        logic [31:0] res;
        s_pmem[0] = 8'($urandom); s_pmem[1] = 8'($urandom);
        s_wmem[0] = $urandom;     s_wmem[1] = s_wmem[0] ^ 32'h0000_1001;
        b = $urandom;
        exp = b + 32'(s_pmem[0]) * s_wmem[0];
`ifdef NEURON_SEQ_RELU_EN
        if (exp[31]) exp = 32'd0;
`endif
        done_cyc = -1; act_cnt = 0; addr_ok = 1'b0; res = 'x; res_seen = 1'b0;
        s_start = 1'b1; s_nsel = 1'b1; s_bias = b;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            s_start = 1'b0;
            s_bias  = $urandom;
            if (c == 3) addr_ok = (s_paddr === 1'b0) && (s_waddr === 1'b0);
            if (s_active) act_cnt++;
            if (s_done && !res_seen) begin done_cyc = c; res = s_result; res_seen = 1'b1; end
        end
        checks++; if (done_cyc !== 6 || act_cnt !== 1) begin
            errors++; $display("FAIL small_timing: done %0d active %0d want 6/1", done_cyc, act_cnt); end
        checks++; if (addr_ok !== 1'b1) begin
            errors++; $display("FAIL small_clamp_addr: paddr/waddr not 0 in FEED"); end
        checks++; if (res !== exp) begin
            errors++; $display("FAIL small_result: got %h want %h", res, exp); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; nsel = '0; bias = '0;
        s_start = 1'b0; s_nsel = 1'b0; s_bias = '0;
        test_reset();
        test_timing();
        test_addressing();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        test_relu();
        test_small();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
